// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array partial-sum accumulator:
// geometry, input lane modes, the output FIFO entry and the saturating adder.
package sa_pkg;

    localparam int ROWS      = 16;
    localparam int ROW_W     = 4;
    localparam int LANES     = 64;
    localparam int ACC_W     = 32;
    localparam int IN_W      = 1024;
    localparam int OUT_DEPTH = 4;
    localparam int OCC_W     = $clog2(OUT_DEPTH + 1);

    // Input lane geometry per mode
    localparam int IN_LANE_W_88 = 24;
    localparam int IN_LANE_W_18 = 16;
    localparam int LANES_88     = 32;

    typedef enum logic [3:0] {
        MODE_88 = 4'd0,
        MODE_18 = 4'd1
    } sa_mode_e;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        logic [ROW_W-1:0]         idx;
        logic [LANES*ACC_W-1:0]   data;
    } out_entry_t;

    // Signed add that clamps to the ACC_W range instead of wrapping
    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/sa_psum_accum_out_fifo.sv
// First-word-fall-through output FIFO with occupancy output.
// A push into a full FIFO is only taken when the head is popped in the same
// cycle; otherwise the incoming entry is discarded and storage is untouched.
module sa_psum_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic                         o_valid,
    output logic [W-1:0]                 o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_occ
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_full    = (r_occ == OCC_W'(DEPTH));
    assign w_do_pop  = i_pop & (r_occ != '0);
    assign w_do_push = i_push & (~w_full | w_do_pop);

    assign o_valid = (r_occ != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_occ   = r_occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sa_psum_accum.sv
// Partial-sum accumulator behind the 16x16 systolic array. Each strobed row is
// unpacked into 64 signed lanes, added into (or overwrites) the stored partial
// sum of its output channel, and on the last pass pushed to the output FIFO.
module sa_psum_accum
    import sa_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             mode,
    input  logic                   channel_out_reset,
    input  logic                   channel_out_en,
    input  logic [IN_W-1:0]        sa_row_in,
    input  logic                   first_pass,
    input  logic                   last_pass,
    output logic                   in_ready,
    output logic [LANES*ACC_W-1:0] out_data,
    output logic [ROW_W-1:0]       out_row_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   pass_done,
    output logic                   err_overflow
);
    logic             w_mode_ok;
    logic             w_accept;
    logic             w_err_evt;
    logic             w_credit_ok;
    logic             w_push;
    logic [OCC_W-1:0] w_occ;
    acc_t             w_lane [LANES];
    acc_t             w_sum  [LANES];
    out_entry_t       w_push_entry;
    out_entry_t       w_head;

    logic [ROW_W-1:0] r_row_cnt;
    logic             r_vld_p1;
    logic             r_first_p1;
    logic             r_last_p1;
    logic [ROW_W-1:0] r_row_p1;
    acc_t             r_lane_p1 [LANES];
    acc_t             r_psum [ROWS][LANES];
    logic             r_pass_done;
    logic             r_err;

    assign w_mode_ok = (mode == MODE_88) | (mode == MODE_18);
    assign w_accept  = channel_out_en & ~channel_out_reset & w_mode_ok;
    assign w_err_evt = channel_out_en & ~channel_out_reset & (~w_mode_ok | ~in_ready);

    // Credit: leave room in the FIFO for every last-pass row already committed
    assign w_credit_ok = (32'(w_occ) + 32'(r_vld_p1 & r_last_p1) + 32'd1) <= 32'(OUT_DEPTH);
    assign in_ready    = ~last_pass | w_credit_ok;

    // Unpack the SA row into sign-extended accumulator lanes
    always_comb begin
        for (int k = 0; k < LANES; k++) w_lane[k] = '0;
        if (mode == MODE_18) begin
            for (int k = 0; k < LANES; k++) begin
                w_lane[k] = {{(ACC_W-IN_LANE_W_18){sa_row_in[k*IN_LANE_W_18 + IN_LANE_W_18-1]}},
                             sa_row_in[k*IN_LANE_W_18 +: IN_LANE_W_18]};
            end
        end else begin
            for (int k = 0; k < LANES_88; k++) begin
                w_lane[k] = {{(ACC_W-IN_LANE_W_88){sa_row_in[k*IN_LANE_W_88 + IN_LANE_W_88-1]}},
                             sa_row_in[k*IN_LANE_W_88 +: IN_LANE_W_88]};
            end
        end
    end

    // Output-channel row counter, cleared by channel_out_reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_cnt <= '0;
        end else if (channel_out_reset) begin
            r_row_cnt <= '0;
        end else if (w_accept) begin
            r_row_cnt <= (r_row_cnt == ROW_W'(ROWS - 1)) ? '0 : r_row_cnt + ROW_W'(1);
        end
    end

    // ---- S1: register accepted row control ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1   <= 1'b0;
            r_row_p1   <= '0;
            r_first_p1 <= 1'b0;
            r_last_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_row_p1   <= r_row_cnt;
                r_first_p1 <= first_pass;
                r_last_p1  <= last_pass;
            end
        end
    end

    // S1 lane data (no reset needed, qualified by r_vld_p1)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < LANES; k++) r_lane_p1[k] <= w_lane[k];
        end
    end

    // ---- S2: accumulate against the stored partial sum ----
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_sum[k] = r_first_p1 ? r_lane_p1[k] : sat_add(r_psum[r_row_p1][k], r_lane_p1[k]);
        end
    end

    // S2 write-back; the next cycle's read of the same row sees this value
    always_ff @(posedge clk) begin
        if (r_vld_p1) begin
            for (int k = 0; k < LANES; k++) r_psum[r_row_p1][k] <= w_sum[k];
        end
    end

    // Pack the finished row for the output FIFO
    always_comb begin
        w_push_entry     = '0;
        w_push_entry.idx = r_row_p1;
        for (int k = 0; k < LANES; k++) w_push_entry.data[k*ACC_W +: ACC_W] = w_sum[k];
    end

    assign w_push = r_vld_p1 & r_last_p1;

    sa_psum_out_fifo #(
        .W     ($bits(out_entry_t)),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_data  (w_head),
        .o_occ   (w_occ)
    );

    assign out_data    = w_head.data;
    assign out_row_idx = w_head.idx;

    // End-of-pass pulse and sticky protocol error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pass_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pass_done <= r_vld_p1 & (r_row_p1 == ROW_W'(ROWS - 1));
            if (w_err_evt) r_err <= 1'b1;
        end
    end

    assign pass_done    = r_pass_done;
    assign err_overflow = r_err;

endmodule

// File: tb/tb_sa_psum_accum.sv
// Bench for sa_psum_accum: directed scenarios plus randomized passes, all
// checked every cycle against a row-level behavioural model.
`timescale 1ns/1ps
module tb_sa_psum_accum;
    import sa_pkg::*;

    localparam int DW = LANES * ACC_W;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      mode;
    logic            channel_out_reset;
    logic            channel_out_en;
    logic [IN_W-1:0] sa_row_in;
    logic            first_pass;
    logic            last_pass;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic [3:0]      out_row_idx;
    logic            out_valid;
    logic            out_ready;
    logic            pass_done;
    logic            err_overflow;

    sa_psum_accum dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .channel_out_reset (channel_out_reset),
        .channel_out_en    (channel_out_en),
        .sa_row_in         (sa_row_in),
        .first_pass        (first_pass),
        .last_pass         (last_pass),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_row_idx       (out_row_idx),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .pass_done         (pass_done),
        .err_overflow      (err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0]   rdy;
        logic [3:0]    idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t   q[$];
    longint m_psum [ROWS][LANES];
    int     m_row = 0;
    int     edge_cnt = 0;
    bit     m_err = 0;
    bit     pd_s1 = 0;
    bit     exp_pd = 0;

    function automatic longint lane_in(input logic [IN_W-1:0] d, input logic [3:0] md, input int k);
        logic signed [15:0] s16;
        logic signed [23:0] s24;
        if (md == 4'd1) begin
            s16 = d[k*16 +: 16];
            return longint'(s16);
        end
        if (k < 32) begin
            s24 = d[k*24 +: 24];
            return longint'(s24);
        end
        return 0;
    endfunction

    function automatic bit m_in_ready();
        return !last_pass || (q.size() + 1 <= OUT_DEPTH);
    endfunction

    function automatic bit m_out_valid();
        return (q.size() > 0) && (int'(q[0].rdy) <= edge_cnt);
    endfunction

    always @(posedge clk or posedge reset) begin
        bit     rdy_now;
        bit     vld_now;
        longint s;
        exp_t   e;
        if (reset) begin
            q.delete();
            m_row    = 0;
            m_err    = 0;
            pd_s1    = 0;
            exp_pd   = 0;
            edge_cnt = 0;
        end else begin
            rdy_now = m_in_ready();
            vld_now = m_out_valid();
            edge_cnt++;
            exp_pd = pd_s1;
            pd_s1  = 0;
            if (vld_now && out_ready) void'(q.pop_front());
            if (channel_out_reset) begin
                m_row = 0;
            end else if (channel_out_en) begin
                if (mode > 4'd1) begin
                    m_err = 1;
                end else begin
                    if (!rdy_now) m_err = 1;
                    e = '0;
                    for (int k = 0; k < LANES; k++) begin
                        s = lane_in(sa_row_in, mode, k);
                        if (!first_pass) begin
                            s = s + m_psum[m_row][k];
                            if (s > 64'sd2147483647)  s = 64'sd2147483647;
                            if (s < -64'sd2147483648) s = -64'sd2147483648;
                        end
                        m_psum[m_row][k] = s;
                        e.data[k*32 +: 32] = s[31:0];
                    end
                    if (last_pass && q.size() < OUT_DEPTH) begin
                        e.idx = 4'(m_row);
                        e.rdy = 32'(edge_cnt + 1);
                        q.push_back(e);
                    end
                    if (m_row == ROWS - 1) pd_s1 = 1;
                    m_row = (m_row + 1) % ROWS;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t h;
        int   bad;
        if (!reset) begin
            chk("in_ready", in_ready, m_in_ready());
            chk("out_valid", out_valid, m_out_valid());
            if (m_out_valid()) begin
                h   = q[0];
                bad = -1;
                for (int k = 0; k < LANES; k++) begin
                    if (bad < 0 && out_data[k*32 +: 32] !== h.data[k*32 +: 32]) bad = k;
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL out_data row %0d lane %0d actual=%h required=%h",
                             h.idx, bad, out_data[bad*32 +: 32], h.data[bad*32 +: 32]);
                end
                chk("out_row_idx", out_row_idx, h.idx);
            end
            chk("pass_done", pass_done, exp_pd);
            chk("err_overflow", err_overflow, m_err);
        end
    end

    // Capture accepted outputs for the literal expectations
    logic [DW-1:0] cap_data [64];
    logic [3:0]    cap_idx  [64];
    int            cap_n  = 0;
    int            pd_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready && cap_n < 64) begin
                cap_data[cap_n] = out_data;
                cap_idx[cap_n]  = out_row_idx;
                cap_n++;
            end
            if (pass_done) pd_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rnd_ready = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [IN_W-1:0] d, input bit f, input bit l);
        int n;
        n = 0;
        first_pass = f;
        last_pass  = l;
        sa_row_in  = d;
        #1;
        while (!in_ready && n < 200) begin
            tick();
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", 1, 0);
        channel_out_en = 1'b1;
        tick();
        channel_out_en = 1'b0;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_cor();
        channel_out_reset = 1'b1;
        tick();
        channel_out_reset = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (q.size() != 0); i++) tick();
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 0);
        repeat (3) tick();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [IN_W-1:0] mk16(input int base, input int step);
        logic [IN_W-1:0] d;
        d = '0;
        for (int k = 0; k < 64; k++) d[k*16 +: 16] = 16'(base + step * k);
        return d;
    endfunction

    function automatic logic [IN_W-1:0] mk24(input logic [23:0] v, input bit upper);
        logic [IN_W-1:0] d;
        d = '0;
        for (int k = 0; k < 32; k++) d[k*24 +: 24] = v;
        if (upper) d[IN_W-1:768] = '1;
        return d;
    endfunction

    function automatic logic [IN_W-1:0] mkrnd();
        logic [IN_W-1:0] d;
        for (int w = 0; w < IN_W / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        reset = 1'b1; mode = 4'd1; channel_out_reset = 1'b0; channel_out_en = 1'b0;
        sa_row_in = '0; first_pass = 1'b0; last_pass = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", |out_data, 0);
        chk("rst_out_row_idx", out_row_idx, 0);
        chk("rst_pass_done", pass_done, 0);
        chk("rst_err", err_overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single pass, rows tagged r*64+k
        cap_n = 0; pd_cnt = 0;
        for (int r = 0; r < 16; r++) send_row(mk16(r * 64, 1), 1, 1);
        drain();
        chk("t1_count", 64'(cap_n), 16);
        chk("t1_pass_done_cnt", 64'(pd_cnt), 1);
        chk("t1_idx5", cap_idx[5], 5);
        chk("t1_r2_l1", cap_data[2][1*32 +: 32], 32'd129);
        chk("t1_r15_l63", cap_data[15][63*32 +: 32], 32'd1023);

        // Three passes of -5
        cap_n = 0;
        for (int p = 0; p < 3; p++)
            for (int r = 0; r < 16; r++) send_row(mk16(-5, 0), p == 0, p == 2);
        drain();
        chk("t2_count", 64'(cap_n), 16);
        chk("t2_r0_l0", cap_data[0][0 +: 32], 32'hFFFF_FFF1);
        chk("t2_r15_l63", cap_data[15][63*32 +: 32], 32'hFFFF_FFF1);

        // Mode 0, two passes of 0x7FFFFF, upper input bits set
        mode = 4'd0; cap_n = 0;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 16; r++) send_row(mk24(24'h7FFFFF, 1), p == 0, p == 1);
        drain();
        chk("t3_count", 64'(cap_n), 16);
        chk("t3_l0", cap_data[4][0 +: 32], 32'h00FF_FFFE);
        chk("t3_l31", cap_data[4][31*32 +: 32], 32'h00FF_FFFE);
        chk("t3_l32", cap_data[4][32*32 +: 32], 32'h0);
        chk("t3_l63", cap_data[4][63*32 +: 32], 32'h0);

        // Positive saturation on row 0
        cap_n = 0;
        send_row(mk24(24'h7FFFFF, 0), 1, 0); pulse_cor();
        for (int i = 1; i < 256; i++) begin send_row(mk24(24'h7FFFFF, 0), 0, 0); pulse_cor(); end
        send_row(mk24(24'h0000F0, 0), 0, 0); pulse_cor();
        send_row(mk24(24'h000100, 0), 0, 1); pulse_cor();
        drain();
        chk("sat_pos_count", 64'(cap_n), 1);
        chk("sat_pos_idx", cap_idx[0], 0);
        chk("sat_pos_l0", cap_data[0][0 +: 32], 32'h7FFF_FFFF);
        chk("sat_pos_l40", cap_data[0][40*32 +: 32], 32'h0);

        // Negative saturation on row 0
        cap_n = 0;
        send_row(mk24(24'h800000, 0), 1, 0); pulse_cor();
        for (int i = 1; i < 256; i++) begin send_row(mk24(24'h800000, 0), 0, 0); pulse_cor(); end
        send_row(mk24(24'hFFFFFF, 0), 0, 1); pulse_cor();
        drain();
        chk("sat_neg_l0", cap_data[0][0 +: 32], 32'h8000_0000);
        chk("sat_neg_l31", cap_data[0][31*32 +: 32], 32'h8000_0000);

        // Backpressure with a stalled consumer
        mode = 4'd1; cap_n = 0;
        begin
            int sent;
            sent = 0;
            out_ready = 1'b0;
            for (int n = 0; n < 12; n++) begin
                sa_row_in = mk16(n * 100, 3); first_pass = 1'b1; last_pass = 1'b1;
                #1;
                if (!in_ready) break;
                channel_out_en = 1'b1;
                tick();
                channel_out_en = 1'b0;
                sent++;
            end
            chk("bp_accepted", 64'(sent), 4);
            sa_row_in = mk16(7777, 1);
            channel_out_en = 1'b1;
            tick();
            channel_out_en = 1'b0;
            chk("bp_err", err_overflow, 1);
            repeat (4) tick();
            chk("bp_in_ready_low", in_ready, 0);
        end
        drain();
        chk("bp_count", 64'(cap_n), 4);
        chk("bp_idx3", cap_idx[3], 3);
        chk("bp_r3_l2", cap_data[3][2*32 +: 32], 32'd306);
        pulse_reset();
        chk("bp_err_cleared", err_overflow, 0);

        // channel_out_reset colliding with the row-7 strobe
        cap_n = 0; pd_cnt = 0;
        for (int r = 0; r < 7; r++) send_row(mk16(r, 0), 1, 1);
        sa_row_in = mk16(555, 0);
        channel_out_en = 1'b1; channel_out_reset = 1'b1;
        tick();
        channel_out_en = 1'b0; channel_out_reset = 1'b0;
        for (int r = 0; r < 3; r++) send_row(mk16(100 + r, 0), 1, 1);
        drain();
        chk("cor_count", 64'(cap_n), 10);
        chk("cor_next_idx", cap_idx[7], 0);
        chk("cor_next_data", cap_data[7][0 +: 32], 32'd100);
        chk("cor_no_pass_done", 64'(pd_cnt), 0);
        chk("cor_no_err", err_overflow, 0);

        // Async reset with results waiting
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) send_row(mk16(r, 2), 1, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();

        // Illegal mode strobe
        mode = 4'd5;
        send_row(mkrnd(), 1, 1);
        repeat (3) tick();
        chk("illegal_err", err_overflow, 1);
        chk("illegal_no_out", out_valid, 0);
        mode = 4'd1;
        pulse_reset();

        // Randomized passes
        rnd_ready = 1;
        for (int p = 0; p < 24; p++) begin
            mode = 4'($urandom_range(0, 1));
            for (int r = 0; r < 16; r++)
                send_row(mkrnd(), (p == 0) || ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
            rnd_ready = 0;
            drain();
            rnd_ready = 1;
        end
        rnd_ready = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
